snake_game_ctrl: RTL and testbench
==================================

// Module: snake_game_ctrl
// PURPOSE
//  Game-sequencing controller for the VGA snake: owns start/pause/game-over FSM, step timer
//  and committed heading. Issues one-cycle move_en steps to the snake datapath and waits for
//  its step_done/collide/eat result. Speeds up per apple; keeps score for the display.
// PARAMETERS
//  STEP_INIT  26'd25_000_000  vga_clk cycles per step after a new game
//  STEP_DEC   26'd1_000_000   period reduction per apple eaten
//  STEP_MIN   26'd5_000_000   floor for step period
// PORTS
//  vga_clk    in   1   pixel clock; sole clock
//  sys_rst    in   1   synchronous, active-high reset
//  key_start  in   1   debounced start/pause key, level, active-high
//  direct_x   in   4   debounced direction keys, active-low: 1110 up, 1101 left, 1011 right, 0111 down
//  step_done  in   1   datapath finished step; collide/eat valid this cycle
//  collide    in   1   head hit wall/body on this step
//  eat        in   1   head reached apple on this step
//  clear_req  out  1   1-cycle pulse: datapath reinitialises snake/apple
//  move_en    out  1   1-cycle pulse: datapath advances one cell
//  direct_s   out  2   committed heading: 00 up, 01 left, 10 right, 11 down
//  sta_en     out  1   high in PLAY and WAIT
//  gameover   out  1   high in OVER
//  score      out  8   apples eaten this game, saturating
// BEHAVIOUR
//  Reset: state IDLE; all pulses 0; direct_s=00; pend_dir=00; sta_en=0; gameover=0; score=0;
//   period=STEP_INIT; tick_cnt=0; start_q=0. Reset mid-step abandons the step; late step_done ignored.
//  start_edge = key_start & ~start_q (start_q registered every cycle).
//  States: IDLE, PLAY, WAIT, PAUSE, OVER.
//   IDLE : start_edge -> clear_req=1 next cycle, score=0, period=STEP_INIT, direct_s=pend_dir=00,
//          tick_cnt=0 -> PLAY.
//   PLAY : tick_cnt++ each cycle; when tick_cnt==period-1: move_en=1 next cycle, direct_s<=pend_dir
//          same edge, tick_cnt=0 -> WAIT. start_edge (same cycle not terminal) -> PAUSE, tick_cnt held.
//          If start_edge and terminal count coincide, step wins; start_edge is dropped.
//   WAIT : tick_cnt held 0; start_edge ignored. On step_done: collide=1 -> OVER (eat ignored);
//          else eat=1 -> score=min(score+1,255), period=max(period-STEP_DEC,STEP_MIN) -> PLAY;
//          else -> PLAY. No timeout; only reset exits a hung WAIT. step_done outside WAIT ignored.
//   PAUSE: counter frozen, no move_en; start_edge -> PLAY, counting resumes from held value.
//   OVER : gameover=1, score held; start_edge -> same actions as IDLE start -> PLAY.
//  Direction: direct_x sampled every cycle in PLAY/WAIT/PAUSE; only exactly-one-zero codes valid,
//   others (1111, multi-key) ignored. Valid code updates pend_dir unless it is the reverse of
//   direct_s (committed, not pending) or equals direct_s. Last valid press before commit wins.
//   Commit only at move_en, so two presses in one step cannot reverse the snake.
//  Period arithmetic unsigned 26-bit; clamp so underflow never occurs (period-STEP_DEC < STEP_MIN
//   or borrow -> STEP_MIN). New period applies from the next PLAY count.
//  Pulses (move_en, clear_req) are registered, exactly one cycle wide, never simultaneous.
// TESTING (STEP_INIT=10, STEP_DEC=3, STEP_MIN=4)
//  Reset, key_start 0->1 -> clear_req 1 cycle, sta_en=1; move_en exactly 10 cycles later, repeats
//   every 10 cycles + WAIT time with step_done returned 2 cycles after move_en.
//  direct_s=00, press 1101 then 0111 within one step -> 0111 rejected (reverse of 00), direct_s=01 at
//   next move_en; 1111 and 1001 never change pend_dir.
//  step_done with eat=1 three times -> score=3, period 10->7->4->4; move_en spacing follows.
//  step_done with collide=1 and eat=1 -> OVER, gameover=1, score unchanged; start edge -> clear_req,
//   score=0, period=10, direct_s=00.
//  Start edge in PLAY at tick_cnt=5 -> PAUSE, no move_en for 100 cycles; start edge -> move_en
//   5 cycles after resume. Held key_start produces no further edges.
//  sys_rst asserted in WAIT, then step_done pulse -> outputs at reset values, state IDLE, score=0.

Source files
------------

// File: rtl/snake_game_ctrl.sv
// Game sequencer for the VGA snake: start/pause/game-over FSM, step timer,
// committed heading and score. Talks to the snake datapath via move_en / step_done.
module snake_game_ctrl #(
    parameter logic [25:0] STEP_INIT = 26'd25_000_000,
    parameter logic [25:0] STEP_DEC  = 26'd1_000_000,
    parameter logic [25:0] STEP_MIN  = 26'd5_000_000
) (
    input  logic       vga_clk,
    input  logic       sys_rst,
    input  logic       key_start,
    input  logic [3:0] direct_x,
    input  logic       step_done,
    input  logic       collide,
    input  logic       eat,
    output logic       clear_req,
    output logic       move_en,
    output logic [1:0] direct_s,
    output logic       sta_en,
    output logic       gameover,
    output logic [7:0] score
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PLAY  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    state_t      state_r, state_n;
    logic        start_q_r;
    logic [25:0] tick_cnt_r, tick_n;
    logic [25:0] period_r, period_n;
    logic [7:0]  score_n;
    logic [1:0]  dir_n, pend_dir_r, pend_n;
    logic        move_n, clear_n;
    logic        start_edge_s;
    logic        active_s;
    logic [1:0]  dir_dec_s;
    logic        dir_vld_s;
    logic        dir_ok_s;

    // Faster step after an apple; clamped so a borrow can never wrap the period.
    function automatic logic [25:0] next_period(input logic [25:0] cur);
        logic [26:0] diff;
        diff = {1'b0, cur} - {1'b0, STEP_DEC};
        if (diff[26] || (diff[25:0] < STEP_MIN)) begin
            next_period = STEP_MIN;
        end else begin
            next_period = diff[25:0];
        end
    endfunction

    assign start_edge_s = key_start & ~start_q_r;
    assign active_s     = (state_r == ST_PLAY) || (state_r == ST_WAIT) || (state_r == ST_PAUSE);

    // Decode one-hot active-low direction keys; anything else is not a press.
    always_comb begin
        dir_dec_s = 2'b00;
        dir_vld_s = 1'b0;
        case (direct_x)
            4'b1110: begin dir_dec_s = 2'b00; dir_vld_s = 1'b1; end
            4'b1101: begin dir_dec_s = 2'b01; dir_vld_s = 1'b1; end
            4'b1011: begin dir_dec_s = 2'b10; dir_vld_s = 1'b1; end
            4'b0111: begin dir_dec_s = 2'b11; dir_vld_s = 1'b1; end
            default: begin dir_dec_s = 2'b00; dir_vld_s = 1'b0; end
        endcase
    end

    // Reverse of a heading is its bitwise complement, checked against the committed heading.
    assign dir_ok_s = dir_vld_s & active_s & (dir_dec_s != direct_s) & (dir_dec_s != ~direct_s);

    // Next-state, timer, scoring and pulse generation.
    always_comb begin
        state_n  = state_r;
        tick_n   = tick_cnt_r;
        period_n = period_r;
        score_n  = score;
        dir_n    = direct_s;
        pend_n   = dir_ok_s ? dir_dec_s : pend_dir_r;
        move_n   = 1'b0;
        clear_n  = 1'b0;
        case (state_r)
            ST_IDLE, ST_OVER: begin
                if (start_edge_s) begin
                    clear_n  = 1'b1;
                    score_n  = 8'd0;
                    period_n = STEP_INIT;
                    dir_n    = 2'b00;
                    pend_n   = 2'b00;
                    tick_n   = 26'd0;
                    state_n  = ST_PLAY;
                end else begin
                    state_n = state_r;
                end
            end
            ST_PLAY: begin
                // Terminal count beats a coincident start edge.
                if (tick_cnt_r >= (period_r - 26'd1)) begin
                    move_n  = 1'b1;
                    dir_n   = pend_dir_r;
                    tick_n  = 26'd0;
                    state_n = ST_WAIT;
                end else if (start_edge_s) begin
                    state_n = ST_PAUSE;
                end else begin
                    tick_n = tick_cnt_r + 26'd1;
                end
            end
            ST_WAIT: begin
                tick_n = 26'd0;
                if (step_done) begin
                    if (collide) begin
                        state_n = ST_OVER;
                    end else if (eat) begin
                        score_n  = (score == 8'hFF) ? 8'hFF : (score + 8'd1);
                        period_n = next_period(period_r);
                        state_n  = ST_PLAY;
                    end else begin
                        state_n = ST_PLAY;
                    end
                end else begin
                    state_n = ST_WAIT;
                end
            end
            ST_PAUSE: begin
                if (start_edge_s) begin
                    state_n = ST_PLAY;
                end else begin
                    state_n = ST_PAUSE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; status flags track the state being entered.
    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            state_r    <= ST_IDLE;
            start_q_r  <= 1'b0;
            tick_cnt_r <= 26'd0;
            period_r   <= STEP_INIT;
            pend_dir_r <= 2'b00;
            direct_s   <= 2'b00;
            score      <= 8'd0;
            move_en    <= 1'b0;
            clear_req  <= 1'b0;
            sta_en     <= 1'b0;
            gameover   <= 1'b0;
        end else begin
            state_r    <= state_n;
            start_q_r  <= key_start;
            tick_cnt_r <= tick_n;
            period_r   <= period_n;
            pend_dir_r <= pend_n;
            direct_s   <= dir_n;
            score      <= score_n;
            move_en    <= move_n;
            clear_req  <= clear_n;
            sta_en     <= (state_n == ST_PLAY) || (state_n == ST_WAIT);
            gameover   <= (state_n == ST_OVER);
        end
    end

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed bench for snake_game_ctrl with a short step period (10/3/4).
module tb_snake_game_ctrl;

    logic       vga_clk = 1'b0;
    logic       sys_rst;
    logic       key_start;
    logic [3:0] direct_x;
    logic       step_done;
    logic       collide;
    logic       eat;
    logic       clear_req;
    logic       move_en;
    logic [1:0] direct_s;
    logic       sta_en;
    logic       gameover;
    logic [7:0] score;

    int n_assert = 0;
    int n_fail   = 0;
    int n;
    int hits;

    snake_game_ctrl #(
        .STEP_INIT(26'd10),
        .STEP_DEC (26'd3),
        .STEP_MIN (26'd4)
    ) dut (
        .vga_clk  (vga_clk),
        .sys_rst  (sys_rst),
        .key_start(key_start),
        .direct_x (direct_x),
        .step_done(step_done),
        .collide  (collide),
        .eat      (eat),
        .clear_req(clear_req),
        .move_en  (move_en),
        .direct_s (direct_s),
        .sta_en   (sta_en),
        .gameover (gameover),
        .score    (score)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic step();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Cycles until move_en is seen; 300 marks an expired budget.
    task automatic wait_move(output int cnt);
        cnt = 0;
        while (cnt < 300) begin
            step();
            cnt++;
            if (move_en === 1'b1) break;
        end
    endtask

    // Return the step result two cycles after move_en.
    task automatic send_done(input logic c, input logic e);
        step();
        check("move_en_width", {31'd0, move_en}, 32'd0);
        step_done = 1'b1;
        collide   = c;
        eat       = e;
        step();
        step_done = 1'b0;
        collide   = 1'b0;
        eat       = 1'b0;
    endtask

    task automatic count_moves(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (move_en === 1'b1) cnt++;
        end
    endtask

    initial begin
        sys_rst   = 1'b1;
        key_start = 1'b0;
        direct_x  = 4'hF;
        step_done = 1'b0;
        collide   = 1'b0;
        eat       = 1'b0;
        step(); step(); step();
        sys_rst = 1'b0;
        step();
        check("rst_clear_req", {31'd0, clear_req}, 32'd0);
        check("rst_move_en",   {31'd0, move_en},   32'd0);
        check("rst_direct_s",  {30'd0, direct_s},  32'd0);
        check("rst_sta_en",    {31'd0, sta_en},    32'd0);
        check("rst_gameover",  {31'd0, gameover},  32'd0);
        check("rst_score",     {24'd0, score},     32'd0);

        // New game: clear pulse, then first step after a full period
        key_start = 1'b1;
        step();
        check("start_clear_req", {31'd0, clear_req}, 32'd1);
        check("start_sta_en",    {31'd0, sta_en},    32'd1);
        check("start_move_en",   {31'd0, move_en},   32'd0);
        step();
        check("clear_req_width", {31'd0, clear_req}, 32'd0);
        wait_move(n);
        check("first_move_gap", n + 1, 32'd10);
        check("first_dir", {30'd0, direct_s}, 32'd0);

        // Left then down (reverse of up) in one step: left commits
        send_done(1'b0, 1'b0);
        direct_x = 4'b1101; step();
        direct_x = 4'b1111; step();
        direct_x = 4'b0111; step();
        direct_x = 4'b1001; step();
        direct_x = 4'b1111;
        wait_move(n);
        check("dir_move_gap", n, 32'd6);
        check("dir_left", {30'd0, direct_s}, 32'd1);

        // Invalid codes and reverse of left never change the pending heading
        send_done(1'b0, 1'b0);
        direct_x = 4'b1001; step();
        direct_x = 4'b1111; step();
        direct_x = 4'b1011; step();
        direct_x = 4'b1111;
        wait_move(n);
        check("dir_hold_gap", n, 32'd7);
        check("dir_hold_left", {30'd0, direct_s}, 32'd1);

        send_done(1'b0, 1'b0);
        direct_x = 4'b0111; step();
        direct_x = 4'b1111;
        wait_move(n);
        check("dir_down_gap", n, 32'd9);
        check("dir_down", {30'd0, direct_s}, 32'd3);

        // Three apples: period 10 -> 7 -> 4 -> 4
        send_done(1'b0, 1'b1);
        wait_move(n);
        check("eat1_gap", n, 32'd7);
        check("eat1_score", {24'd0, score}, 32'd1);
        send_done(1'b0, 1'b1);
        wait_move(n);
        check("eat2_gap", n, 32'd4);
        check("eat2_score", {24'd0, score}, 32'd2);
        send_done(1'b0, 1'b1);
        wait_move(n);
        check("eat3_gap", n, 32'd4);
        check("eat3_score", {24'd0, score}, 32'd3);

        // Collision wins over eat
        send_done(1'b1, 1'b1);
        check("over_gameover", {31'd0, gameover}, 32'd1);
        check("over_sta_en",   {31'd0, sta_en},   32'd0);
        check("over_score",    {24'd0, score},    32'd3);
        count_moves(5, hits);
        check("over_no_move", hits, 32'd0);

        // Restart from OVER
        key_start = 1'b0; step();
        key_start = 1'b1; step();
        check("restart_clear_req", {31'd0, clear_req}, 32'd1);
        check("restart_score",     {24'd0, score},     32'd0);
        check("restart_gameover",  {31'd0, gameover},  32'd0);
        check("restart_dir",       {30'd0, direct_s},  32'd0);
        step();
        wait_move(n);
        check("restart_gap", n + 1, 32'd10);

        // Pause at tick 5, held key gives no new edge, resume finishes the step
        send_done(1'b0, 1'b0);
        key_start = 1'b0;
        step(); step(); step(); step(); step();
        key_start = 1'b1;
        step();
        check("pause_sta_en", {31'd0, sta_en}, 32'd0);
        count_moves(100, hits);
        check("pause_no_move", hits, 32'd0);
        key_start = 1'b0; step();
        key_start = 1'b1; step();
        check("resume_sta_en", {31'd0, sta_en}, 32'd1);
        wait_move(n);
        check("resume_gap", n, 32'd5);

        // Reset during WAIT, then a late step_done is ignored
        key_start = 1'b0;
        sys_rst   = 1'b1;
        step();
        sys_rst   = 1'b0;
        step_done = 1'b1;
        eat       = 1'b1;
        step();
        step_done = 1'b0;
        eat       = 1'b0;
        step();
        check("wrst_sta_en",   {31'd0, sta_en},   32'd0);
        check("wrst_gameover", {31'd0, gameover}, 32'd0);
        check("wrst_score",    {24'd0, score},    32'd0);
        check("wrst_direct_s", {30'd0, direct_s}, 32'd0);
        check("wrst_clear",    {31'd0, clear_req}, 32'd0);
        count_moves(20, hits);
        check("wrst_idle_no_move", hits, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
